// File: rtl/axi_lite_master_p.sv
// AXI4-Lite master that turns single-beat application read/write commands into bus transactions.
// Independent write and read FSMs, each with its own dead-slave timeout.
module axi_lite_master_p #(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [2:0] PROT    = 3'b000,
  parameter int         TIMEOUT = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic                app_wen,
  input  logic [ADDR_W-1:0]   app_waddr,
  input  logic [DATA_W-1:0]   app_wdata,
  input  logic [DATA_W/8-1:0] app_wstrb,
  output logic                app_wbusy,
  output logic                app_wdone,
  output logic [1:0]          app_wresp,
  output logic                app_wtimeout,
  input  logic                app_ren,
  input  logic [ADDR_W-1:0]   app_raddr,
  output logic                app_rbusy,
  output logic                app_rdone,
  output logic [DATA_W-1:0]   app_rdata,
  output logic [1:0]          app_rresp,
  output logic                app_rtimeout
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Expiry is taken at the edge closing the TIMEOUT-th busy cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t         w_state_reg, w_state_next;
  logic             aw_pend_reg, aw_pend_next, w_pend_reg, w_pend_next;
  logic [CNT_W-1:0] w_cnt_reg;
  logic             w_accept, w_complete, w_abort;

  r_state_t         r_state_reg, r_state_next;
  logic [CNT_W-1:0] r_cnt_reg;
  logic             r_accept, r_complete, r_abort;

  assign m_axi_awprot = PROT;
  assign m_axi_arprot = PROT;

  // ---------------- write path ----------------
  assign w_accept   = (w_state_reg == W_IDLE) && app_wen;
  assign w_complete = (w_state_reg == W_RESP) && m_axi_bvalid;
  // A final handshake coinciding with expiry wins over the abort.
  assign w_abort    = (TIMEOUT != 0) && (w_state_reg != W_IDLE) &&
                      (w_cnt_reg == CNT_LAST) && !w_complete;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_reg <= W_IDLE;
      aw_pend_reg <= 1'b0;
      w_pend_reg  <= 1'b0;
      w_cnt_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      aw_pend_reg <= aw_pend_next;
      w_pend_reg  <= w_pend_next;
      if (w_accept)
        w_cnt_reg <= '0;
      else if (w_state_reg != W_IDLE)
        w_cnt_reg <= w_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    aw_pend_next = aw_pend_reg;
    w_pend_next  = w_pend_reg;
    case (w_state_reg)
      W_IDLE: if (app_wen) begin
        w_state_next = W_REQ;
        aw_pend_next = 1'b1;
        w_pend_next  = 1'b1;
      end
      W_REQ: begin
        aw_pend_next = aw_pend_reg && !m_axi_awready;
        w_pend_next  = w_pend_reg && !m_axi_wready;
        if (!aw_pend_next && !w_pend_next)
          w_state_next = W_RESP;
      end
      W_RESP: if (m_axi_bvalid) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    if (w_abort) begin
      w_state_next = W_IDLE;
      aw_pend_next = 1'b0;
      w_pend_next  = 1'b0;
    end
  end

  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    app_wbusy     = 1'b0;
    case (w_state_reg)
      W_REQ: begin
        m_axi_awvalid = aw_pend_reg;
        m_axi_wvalid  = w_pend_reg;
        app_wbusy     = 1'b1;
      end
      W_RESP: begin
        m_axi_bready = 1'b1;
        app_wbusy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
      app_wdone    <= 1'b0;
      app_wresp    <= 2'b00;
      app_wtimeout <= 1'b0;
    end else begin
      app_wdone <= w_complete || w_abort;
      if (w_accept) begin
        m_axi_awaddr <= app_waddr;
        m_axi_wdata  <= app_wdata;
        m_axi_wstrb  <= app_wstrb;
      end
      if (w_complete) begin
        app_wresp    <= m_axi_bresp;
        app_wtimeout <= 1'b0;
      end else if (w_abort) begin
        app_wresp    <= 2'b10;
        app_wtimeout <= 1'b1;
      end
    end
  end

  // ---------------- read path ----------------
  assign r_accept   = (r_state_reg == R_IDLE) && app_ren;
  assign r_complete = (r_state_reg == R_DATA) && m_axi_rvalid;
  assign r_abort    = (TIMEOUT != 0) && (r_state_reg != R_IDLE) &&
                      (r_cnt_reg == CNT_LAST) && !r_complete;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (r_accept)
        r_cnt_reg <= '0;
      else if (r_state_reg != R_IDLE)
        r_cnt_reg <= r_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (app_ren) r_state_next = R_ADDR;
      R_ADDR:  if (m_axi_arready) r_state_next = R_DATA;
      R_DATA:  if (m_axi_rvalid) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
    if (r_abort) r_state_next = R_IDLE;
  end

  always_comb begin
    m_axi_arvalid = (r_state_reg == R_ADDR);
    m_axi_rready  = (r_state_reg == R_DATA);
    app_rbusy     = (r_state_reg != R_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi_araddr <= '0;
      app_rdone    <= 1'b0;
      app_rdata    <= '0;
      app_rresp    <= 2'b00;
      app_rtimeout <= 1'b0;
    end else begin
      app_rdone <= r_complete || r_abort;
      if (r_accept)
        m_axi_araddr <= app_raddr;
      if (r_complete) begin
        app_rdata    <= m_axi_rdata;
        app_rresp    <= m_axi_rresp;
        app_rtimeout <= 1'b0;
      end else if (r_abort) begin
        app_rdata    <= '0;
        app_rresp    <= 2'b10;
        app_rtimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_p.sv
// Directed bench for axi_lite_master_p: cycle-accurate checks of handshakes, results and timeout.
// Inputs change and outputs are sampled on the falling edge; cycle n follows rising edge n-1.
module tb_axi_lite_master_p;
  logic        aclk, aresetn;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic        app_wen, app_wbusy, app_wdone, app_wtimeout;
  logic [31:0] app_waddr, app_wdata, app_raddr, app_rdata;
  logic [3:0]  app_wstrb;
  logic [1:0]  app_wresp, app_rresp;
  logic        app_ren, app_rbusy, app_rdone, app_rtimeout;

  int checks = 0;
  int failures = 0;
  int aw_hs = 0;

  axi_lite_master_p #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000), .TIMEOUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .app_wen(app_wen), .app_waddr(app_waddr), .app_wdata(app_wdata), .app_wstrb(app_wstrb),
    .app_wbusy(app_wbusy), .app_wdone(app_wdone), .app_wresp(app_wresp),
    .app_wtimeout(app_wtimeout),
    .app_ren(app_ren), .app_raddr(app_raddr), .app_rbusy(app_rbusy), .app_rdone(app_rdone),
    .app_rdata(app_rdata), .app_rresp(app_rresp), .app_rtimeout(app_rtimeout)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) if (m_axi_awvalid && m_axi_awready) aw_hs <= aw_hs + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    aresetn = 1'b0;
    app_wen = 0; app_waddr = 0; app_wdata = 0; app_wstrb = 0;
    app_ren = 0; app_raddr = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    repeat (2) @(negedge aclk);
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      failures++; $display("FAIL reset_axi_ctrl: got %b expected 00000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if ({app_wbusy, app_wdone, app_wresp, app_wtimeout, app_rbusy, app_rdone, app_rresp, app_rtimeout} !== 10'b0) begin
      failures++; $display("FAIL reset_app_ctrl: got %b expected 0",
        {app_wbusy, app_wdone, app_wresp, app_wtimeout, app_rbusy, app_rdone, app_rresp, app_rtimeout}); end
    checks++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr, app_rdata} !== 132'b0) begin
      failures++; $display("FAIL reset_payload: got nonzero address/data, expected 0"); end
    aresetn = 1'b1;
    @(negedge aclk);
    $display("transaction reset: done");
  endtask

  task automatic test_write_ready;
    @(negedge aclk);
    m_axi_awready = 1; m_axi_wready = 1;
    app_wen = 1; app_waddr = 32'h10; app_wdata = 32'hDEADBEEF; app_wstrb = 4'hF;
    @(negedge aclk);  // cycle 1
    app_wen = 0;
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, app_wbusy} !== 4'b1101) begin
      failures++; $display("FAIL wr_c1_ctrl: got %b expected 1101", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, app_wbusy}); end
    checks++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
      failures++; $display("FAIL wr_c1_payload: got %h %h %h expected 10 deadbeef f", m_axi_awaddr, m_axi_wdata, m_axi_wstrb); end
    @(negedge aclk);  // cycle 2
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
      failures++; $display("FAIL wr_c2_ctrl: got %b expected 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    @(negedge aclk);  // cycle 3
    m_axi_bvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
    checks++; if ({app_wdone, app_wbusy, app_wresp, app_wtimeout} !== 5'b10000) begin
      failures++; $display("FAIL wr_c3_done: got %b expected 10000", {app_wdone, app_wbusy, app_wresp, app_wtimeout}); end
    @(negedge aclk);
    checks++; if (app_wdone !== 1'b0) begin
      failures++; $display("FAIL wr_done_pulse: got %b expected 0", app_wdone); end
    $display("transaction write addr=10 data=deadbeef resp=%b", app_wresp);
  endtask

  task automatic test_write_skewed;
    @(negedge aclk);
    m_axi_awready = 0; m_axi_wready = 1;
    app_wen = 1; app_waddr = 32'h44; app_wdata = 32'hA5A55A5A; app_wstrb = 4'b0101;
    @(negedge aclk);  // cycle 1
    app_wen = 0;
    checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin
      failures++; $display("FAIL skew_c1: got %b expected 11", {m_axi_awvalid, m_axi_wvalid}); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      m_axi_wready = 0;
      checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100) begin
        failures++; $display("FAIL skew_c%0d_ctrl: got %b expected 100", c, {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
      checks++; if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== {32'h44, 32'hA5A55A5A, 4'b0101}) begin
        failures++; $display("FAIL skew_c%0d_payload: got %h %h %h expected 44 a5a55a5a 5", c, m_axi_awaddr, m_axi_wdata, m_axi_wstrb); end
    end
    m_axi_awready = 1;  // handshake at edge 4
    @(negedge aclk);  // cycle 5
    m_axi_awready = 0;
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
      failures++; $display("FAIL skew_c5_ctrl: got %b expected 001", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b01;
    @(negedge aclk);  // cycle 6
    m_axi_bvalid = 0;
    checks++; if ({app_wdone, app_wresp, app_wtimeout} !== 4'b1010) begin
      failures++; $display("FAIL skew_done: got %b expected 1010", {app_wdone, app_wresp, app_wtimeout}); end
    $display("transaction skewed write addr=44 resp=%b", app_wresp);
  endtask

  task automatic test_read_slverr;
    @(negedge aclk);
    m_axi_arready = 1; app_ren = 1; app_raddr = 32'h20;
    @(negedge aclk);  // cycle 1
    app_ren = 0;
    checks++; if ({m_axi_arvalid, m_axi_rready, app_rbusy, m_axi_araddr} !== {3'b101, 32'h20}) begin
      failures++; $display("FAIL rd_c1: got %b %h expected 101 20", {m_axi_arvalid, m_axi_rready, app_rbusy}, m_axi_araddr); end
    @(negedge aclk);  // cycle 2
    m_axi_arready = 0;
    checks++; if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin
      failures++; $display("FAIL rd_c2: got %b expected 01", {m_axi_arvalid, m_axi_rready}); end
    for (int c = 3; c <= 4; c++) begin
      @(negedge aclk);
      checks++; if ({m_axi_rready, app_rdone} !== 2'b10) begin
        failures++; $display("FAIL rd_wait_c%0d: got %b expected 10", c, {m_axi_rready, app_rdone}); end
    end
    m_axi_rvalid = 1; m_axi_rdata = 32'h12345678; m_axi_rresp = 2'b10;
    @(negedge aclk);  // cycle 5
    m_axi_rvalid = 0; m_axi_rdata = 32'h0;
    checks++; if ({app_rdone, app_rbusy, app_rresp, app_rtimeout} !== 5'b10100) begin
      failures++; $display("FAIL rd_done: got %b expected 10100", {app_rdone, app_rbusy, app_rresp, app_rtimeout}); end
    checks++; if (app_rdata !== 32'h12345678) begin
      failures++; $display("FAIL rd_data: got %h expected 12345678", app_rdata); end
    @(negedge aclk);
    checks++; if ({app_rdone, app_rdata} !== {1'b0, 32'h12345678}) begin
      failures++; $display("FAIL rd_hold: got %b %h expected 0 12345678", app_rdone, app_rdata); end
    $display("transaction read addr=20 data=%h resp=%b", app_rdata, app_rresp);
  endtask

  task automatic test_concurrent;
    int aw_base;
    @(negedge aclk);
    aw_base = aw_hs;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    app_wen = 1; app_waddr = 32'h100; app_wdata = 32'h11112222; app_wstrb = 4'hF;
    app_ren = 1; app_raddr = 32'h200;
    @(negedge aclk);  // cycle 1: second write while busy must be dropped
    app_ren = 0; app_waddr = 32'h300; app_wdata = 32'h33333333;
    checks++; if ({m_axi_awvalid, m_axi_arvalid, m_axi_awaddr, m_axi_araddr} !== {2'b11, 32'h100, 32'h200}) begin
      failures++; $display("FAIL conc_c1: got %b %h %h expected 11 100 200", {m_axi_awvalid, m_axi_arvalid}, m_axi_awaddr, m_axi_araddr); end
    @(negedge aclk);  // cycle 2
    app_wen = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    checks++; if ({m_axi_bready, m_axi_rready, m_axi_awaddr} !== {2'b11, 32'h100}) begin
      failures++; $display("FAIL conc_c2: got %b %h expected 11 100", {m_axi_bready, m_axi_rready}, m_axi_awaddr); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    m_axi_rvalid = 1; m_axi_rdata = 32'h0BADF00D; m_axi_rresp = 2'b00;
    @(negedge aclk);  // cycle 3
    m_axi_bvalid = 0; m_axi_rvalid = 0;
    checks++; if ({app_wdone, app_rdone, app_rdata} !== {2'b11, 32'h0BADF00D}) begin
      failures++; $display("FAIL conc_done: got %b %h expected 11 0badf00d", {app_wdone, app_rdone}, app_rdata); end
    @(negedge aclk);
    checks++; if (aw_hs - aw_base !== 1 || app_wbusy !== 1'b0) begin
      failures++; $display("FAIL conc_aw_count: got %0d busy=%b expected 1 busy=0", aw_hs - aw_base, app_wbusy); end
    $display("transaction concurrent write/read aw_handshakes=%0d", aw_hs - aw_base);
  endtask

  task automatic test_timeout;
    @(negedge aclk);
    m_axi_awready = 1; m_axi_wready = 1;
    app_wen = 1; app_waddr = 32'h80; app_wdata = 32'h55AA55AA; app_wstrb = 4'h3;
    @(negedge aclk);  // cycle 1
    app_wen = 0;
    for (int c = 2; c <= 16; c++) begin
      @(negedge aclk);
      m_axi_awready = 0; m_axi_wready = 0;
      checks++; if ({m_axi_bready, app_wbusy, app_wdone} !== 3'b110) begin
        failures++; $display("FAIL to_wait_c%0d: got %b expected 110", c, {m_axi_bready, app_wbusy, app_wdone}); end
    end
    @(negedge aclk);  // cycle 17
    checks++; if ({m_axi_bready, app_wbusy, app_wdone, app_wresp, app_wtimeout} !== 6'b001101) begin
      failures++; $display("FAIL to_abort: got %b expected 001101", {m_axi_bready, app_wbusy, app_wdone, app_wresp, app_wtimeout}); end
    $display("transaction write timeout resp=%b timeout=%b", app_wresp, app_wtimeout);
    m_axi_awready = 1; m_axi_wready = 1;
    app_wen = 1; app_waddr = 32'h84; app_wdata = 32'h0; app_wstrb = 4'h0;
    @(negedge aclk);
    app_wen = 0;
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wstrb} !== {2'b11, 4'h0}) begin
      failures++; $display("FAIL to_next_req: got %b %h expected 11 0", {m_axi_awvalid, m_axi_wvalid}, m_axi_wstrb); end
    @(negedge aclk);
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    @(negedge aclk);
    m_axi_bvalid = 0;
    checks++; if ({app_wdone, app_wresp, app_wtimeout} !== 4'b1000) begin
      failures++; $display("FAIL to_next_done: got %b expected 1000", {app_wdone, app_wresp, app_wtimeout}); end
    $display("transaction write after timeout resp=%b", app_wresp);
  endtask

  task automatic test_reset_mid_read;
    @(negedge aclk);
    m_axi_arready = 1; app_ren = 1; app_raddr = 32'h40;
    @(negedge aclk);
    app_ren = 0;
    @(negedge aclk);  // cycle 2: in R_DATA
    m_axi_arready = 0;
    checks++; if (m_axi_rready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: got %b expected 1", m_axi_rready); end
    aresetn = 1'b0;
    #1;
    checks++; if ({m_axi_rready, app_rbusy, app_rdone} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_async: got %b expected 000", {m_axi_rready, app_rbusy, app_rdone}); end
    @(negedge aclk);
    aresetn = 1'b1;
    checks++; if (app_rdone !== 1'b0) begin
      failures++; $display("FAIL rst_mid_nodone: got %b expected 0", app_rdone); end
    @(negedge aclk);
    m_axi_arready = 1; app_ren = 1; app_raddr = 32'h44;
    @(negedge aclk);
    app_ren = 0;
    checks++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 32'h44}) begin
      failures++; $display("FAIL rst_new_ar: got %b %h expected 1 44", m_axi_arvalid, m_axi_araddr); end
    @(negedge aclk);
    m_axi_arready = 0;
    m_axi_rvalid = 1; m_axi_rdata = 32'hCAFEF00D; m_axi_rresp = 2'b00;
    @(negedge aclk);
    m_axi_rvalid = 0;
    checks++; if ({app_rdone, app_rresp, app_rtimeout, app_rdata} !== {4'b1000, 32'hCAFEF00D}) begin
      failures++; $display("FAIL rst_new_done: got %b %h expected 1000 cafef00d", {app_rdone, app_rresp, app_rtimeout}, app_rdata); end
    $display("transaction read after reset data=%h", app_rdata);
  endtask

  initial begin
    test_reset();
    test_write_ready();
    test_write_skewed();
    test_read_slverr();
    test_concurrent();
    test_timeout();
    test_reset_mid_read();
    repeat (2) @(negedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
